// File: rtl/dro_access_ctrl.sv
// Shares one DRO cell between a write and a read requester, spacing set/reset edges
// and turning out-line toggles into read data and protocol-error flags.
module dro_access_ctrl #(
  parameter int MIN_GAP     = 3,
  parameter int RD_TIMEOUT  = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wr_req,
  output logic wr_ack,
  input  logic rd_req,
  output logic rd_ack,
  output logic rd_valid,
  output logic rd_data,
  output logic set,
  output logic reset,
  input  logic out,
  output logic busy,
  output logic err,
  input  logic err_clr
);

  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  localparam logic [GW-1:0] GAP_LOAD  = GW'(MIN_GAP - 1);
  localparam logic [TW-1:0] TO_LOAD   = TW'(RD_TIMEOUT);
  localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_GAP,
    S_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] init_cnt, init_nxt;
  logic [GW-1:0] gap_cnt, gap_nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic          ptr, ptr_nxt;        // 0: write side has priority, 1: read side
  logic          stored, stored_nxt;
  logic          seen, seen_nxt;
  logic          out_q;
  logic          set_nxt, reset_nxt;
  logic          wr_ack_nxt, rd_ack_nxt, rd_valid_nxt, rd_data_nxt;
  logic          busy_nxt, err_nxt, err_set;
  logic          can_grant, grant_wr, grant_rd, leave_wait;
  logic          toggle;

  assign toggle = out ^ out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_cnt <= INIT_LOAD;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      ptr      <= 1'b0;
      stored   <= 1'b0;
      seen     <= 1'b0;
      out_q    <= out;
      set      <= 1'b0;
      reset    <= 1'b0;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_nxt;
      gap_cnt  <= gap_nxt;
      to_cnt   <= to_nxt;
      ptr      <= ptr_nxt;
      stored   <= stored_nxt;
      seen     <= seen_nxt;
      out_q    <= out;
      set      <= set_nxt;
      reset    <= reset_nxt;
      wr_ack   <= wr_ack_nxt;
      rd_ack   <= rd_ack_nxt;
      rd_valid <= rd_valid_nxt;
      rd_data  <= rd_data_nxt;
      busy     <= busy_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_nxt     = init_cnt;
    gap_nxt      = (gap_cnt != '0) ? gap_cnt - GW'(1) : '0;
    to_nxt       = to_cnt;
    ptr_nxt      = ptr;
    stored_nxt   = stored;
    seen_nxt     = seen;
    set_nxt      = set;
    reset_nxt    = reset;
    wr_ack_nxt   = 1'b0;
    rd_ack_nxt   = 1'b0;
    rd_valid_nxt = 1'b0;
    rd_data_nxt  = rd_data;
    err_set      = 1'b0;
    can_grant    = 1'b0;
    grant_wr     = 1'b0;
    grant_rd     = 1'b0;
    leave_wait   = 1'b0;

    case (state)
      S_INIT: begin
        // Cell state is undefined here, so out-line activity is not an error yet.
        if (init_cnt == '0) begin
          can_grant = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          init_nxt = init_cnt - IW'(1);
        end
      end
      S_IDLE: begin
        can_grant = 1'b1;
        err_set   = toggle;
      end
      S_GAP: begin
        err_set = toggle;
        if (gap_cnt <= GW'(1)) state_nxt = S_IDLE;
      end
      S_WAIT: begin
        if (stored) begin
          if (toggle) begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = 1'b1;
            leave_wait   = 1'b1;
          end else if (to_cnt == '0) begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = 1'b0;
            err_set      = 1'b1;
            leave_wait   = 1'b1;
          end else begin
            to_nxt = to_cnt - TW'(1);
          end
        end else begin
          // Empty cell: the full window is always observed; any toggle is a fault.
          err_set  = toggle;
          seen_nxt = seen | toggle;
          if (to_cnt == '0) begin
            rd_valid_nxt = 1'b1;
            rd_data_nxt  = seen | toggle;
            leave_wait   = 1'b1;
          end else begin
            to_nxt = to_cnt - TW'(1);
          end
        end
      end
      default: state_nxt = S_INIT;
    endcase

    if (leave_wait) begin
      stored_nxt = 1'b0;
      state_nxt  = (gap_nxt != '0) ? S_GAP : S_IDLE;
    end

    if (can_grant) begin
      if (wr_req && (!rd_req || !ptr)) grant_wr = 1'b1;
      else if (rd_req)                 grant_rd = 1'b1;
    end

    if (grant_wr) begin
      set_nxt    = ~set;
      wr_ack_nxt = 1'b1;
      stored_nxt = 1'b1;
      gap_nxt    = GAP_LOAD;
      ptr_nxt    = 1'b1;
      state_nxt  = (MIN_GAP > 1) ? S_GAP : S_IDLE;
    end else if (grant_rd) begin
      reset_nxt  = ~reset;
      rd_ack_nxt = 1'b1;
      to_nxt     = TO_LOAD;
      seen_nxt   = 1'b0;
      gap_nxt    = GAP_LOAD;
      ptr_nxt    = 1'b0;
      state_nxt  = S_WAIT;
    end

    busy_nxt = (state_nxt == S_GAP) || (state_nxt == S_WAIT);
    err_nxt  = err_set ? 1'b1 : (err_clr ? 1'b0 : err);
  end

endmodule

// File: tb/tb_dro_access_ctrl.sv
// Directed bench for dro_access_ctrl; the DRO out line is driven by hand in each scenario.
module tb_dro_access_ctrl;

  logic clk = 1'b0;
  logic rst_n, wr_req, rd_req, out, err_clr;
  logic wr_ack, rd_ack, rd_valid, rd_data, set, reset, busy, err;

  int checks = 0;
  int errors = 0;

  dro_access_ctrl #(.MIN_GAP(3), .RD_TIMEOUT(4), .INIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .set(set), .reset(reset), .out(out),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input bit rd, output int n);
    bit done;
    n = -1;
    done = 1'b0;
    for (int i = 1; i <= 16 && !done; i++) begin
      tick();
      if ((rd ? rd_ack : wr_ack) === 1'b1) begin
        n = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; out = 1'b0; err_clr = 1'b0;
    tick(); tick();
    checks++;
    if ({wr_ack, rd_ack, rd_valid, rd_data, set, reset, busy, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {wr_ack, rd_ack, rd_valid, rd_data, set, reset, busy, err});
    end
    rst_n = 1'b1; wr_req = 1'b1;
    tick();
    checks++;
    if ({wr_ack, set, busy} !== 3'b000) begin
      errors++;
      $display("FAIL init_edge1: {wr_ack,set,busy} got %b expected 000", {wr_ack, set, busy});
    end
    tick();
    checks++;
    if ({wr_ack, set} !== 2'b11) begin
      errors++;
      $display("FAIL init_first_grant: {wr_ack,set} got %b expected 11", {wr_ack, set});
    end
    wr_req = 1'b0;
    tick();
    checks++;
    if ({wr_ack, set, busy} !== 3'b011) begin
      errors++;
      $display("FAIL after_grant: {wr_ack,set,busy} got %b expected 011", {wr_ack, set, busy});
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: got %b expected 0", busy);
    end
  endtask

  task automatic test_write_read;
    int n;
    logic v1, v2, any_v;
    wr_req = 1'b1;
    wait_ack(1'b0, n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL wr_grant_latency: got %0d expected 1", n);
    end
    wr_req = 1'b0; rd_req = 1'b1;
    wait_ack(1'b1, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL wr_rd_spacing: got %0d expected 3", n);
    end
    rd_req = 1'b0;
    tick(); v1 = rd_valid;
    tick(); v2 = rd_valid;
    out = ~out;
    tick();
    checks++;
    if ({v1, v2, rd_valid, rd_data, err} !== 5'b00110) begin
      errors++;
      $display("FAIL read_one: {v1,v2,rd_valid,rd_data,err} got %b expected 00110",
               {v1, v2, rd_valid, rd_data, err});
    end
    rd_req = 1'b1;
    wait_ack(1'b1, n);
    checks++;
    if (n !== 1) begin
      errors++;
      $display("FAIL read_empty_grant: got %0d expected 1", n);
    end
    rd_req = 1'b0;
    any_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_v |= rd_valid;
    end
    tick();
    checks++;
    if ({any_v, rd_valid, rd_data, err} !== 4'b0100) begin
      errors++;
      $display("FAIL read_empty: {early,rd_valid,rd_data,err} got %b expected 0100",
               {any_v, rd_valid, rd_data, err});
    end
  endtask

  task automatic test_contention;
    logic acc;
    tick(); tick();
    wr_req = 1'b1; rd_req = 1'b1;
    tick();
    checks++;
    if ({wr_ack, rd_ack} !== 2'b10) begin
      errors++;
      $display("FAIL contention_first: {wr_ack,rd_ack} got %b expected 10", {wr_ack, rd_ack});
    end
    tick(); acc = wr_ack | rd_ack;
    tick(); acc |= wr_ack | rd_ack;
    tick();
    checks++;
    if ({acc, wr_ack, rd_ack} !== 3'b001) begin
      errors++;
      $display("FAIL contention_second: {gap_ack,wr_ack,rd_ack} got %b expected 001",
               {acc, wr_ack, rd_ack});
    end
    rd_req = 1'b0;
    out = ~out;
    tick();
    checks++;
    if ({rd_valid, rd_data, err} !== 3'b110) begin
      errors++;
      $display("FAIL contention_read: {rd_valid,rd_data,err} got %b expected 110",
               {rd_valid, rd_data, err});
    end
    tick(); acc = wr_ack;
    tick();
    checks++;
    if ({acc, wr_ack} !== 2'b01) begin
      errors++;
      $display("FAIL contention_third: {early_wr_ack,wr_ack} got %b expected 01", {acc, wr_ack});
    end
    wr_req = 1'b0;
  endtask

  task automatic test_spacing;
    int edges[4];
    int n;
    logic prev;
    tick(); tick();
    n = 0;
    prev = set;
    wr_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (set !== prev) begin
        if (n < 4) edges[n] = i;
        n++;
      end
      prev = set;
      if (n >= 4) wr_req = 1'b0;
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL spacing_count: got %0d edges expected 4", n);
    end
    checks++;
    if (edges[0] !== 1 || edges[1] !== 4 || edges[2] !== 7 || edges[3] !== 10) begin
      errors++;
      $display("FAIL spacing_cycles: got %0d %0d %0d %0d expected 1 4 7 10",
               edges[0], edges[1], edges[2], edges[3]);
    end
  endtask

  task automatic test_err;
    int n;
    logic any_v;
    tick();
    wr_req = 1'b1;
    tick();
    checks++;
    if (wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL err_write: wr_ack got %b expected 1", wr_ack);
    end
    wr_req = 1'b0; rd_req = 1'b1;
    wait_ack(1'b1, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL err_read_grant: got %0d expected 3", n);
    end
    rd_req = 1'b0;
    any_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_v |= rd_valid;
    end
    tick();
    checks++;
    if ({any_v, rd_valid, rd_data, err} !== 4'b0101) begin
      errors++;
      $display("FAIL silent_read: {early,rd_valid,rd_data,err} got %b expected 0101",
               {any_v, rd_valid, rd_data, err});
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
    out = ~out;
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL spurious_toggle: err got %b expected 1", err);
    end
    err_clr = 1'b1;
    out = ~out;
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear: err got %b expected 1", err);
    end
    tick();
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear2: got %b expected 0", err);
    end
  endtask

  task automatic test_reset_mid_read;
    int n;
    logic any_v, pre_busy;
    tick();
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0; rd_req = 1'b1;
    wait_ack(1'b1, n);
    rd_req = 1'b0;
    tick();
    pre_busy = busy;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pre_busy, wr_ack, rd_ack, rd_valid, rd_data, set, reset, busy, err} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL async_reset: {pre_busy,outputs} got %b expected 100000000",
               {pre_busy, wr_ack, rd_ack, rd_valid, rd_data, set, reset, busy, err});
    end
    tick(); tick();
    any_v = rd_valid;
    rst_n = 1'b1; wr_req = 1'b1;
    tick(); any_v |= rd_valid | wr_ack;
    tick(); any_v |= rd_valid;
    checks++;
    if ({any_v, wr_ack, set} !== 3'b011) begin
      errors++;
      $display("FAIL resume_write: {stray,wr_ack,set} got %b expected 011", {any_v, wr_ack, set});
    end
    wr_req = 1'b0; rd_req = 1'b1;
    wait_ack(1'b1, n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL resume_read_grant: got %0d expected 3", n);
    end
    rd_req = 1'b0;
    out = ~out;
    tick();
    checks++;
    if ({rd_valid, rd_data, err} !== 3'b110) begin
      errors++;
      $display("FAIL resume_read: {rd_valid,rd_data,err} got %b expected 110",
               {rd_valid, rd_data, err});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_contention();
    test_spacing();
    test_err();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
